riscv_top: RTL and testbench

//  Top level of a single-cycle RV32I-subset processor. Holds PC, 32x32 register file, ALU and a unified

---
 rtl/riscv_top.sv | 144 ++++++++++++++
 tb/tb_riscv_top.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_top.sv
// Single-cycle RV32I-subset core: PC, 32x32 register file, ALU, a unified word-addressed
// instruction/data memory loaded through a flash port, and a memory-mapped output register.
module riscv_top #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MEM_WORDS = 512,
    parameter logic [31:0] OUT_ADDR  = 32'hFFFF_FFFC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] flash_addr,
    input  logic [WIDTH-1:0] flash_data,
    input  logic             flash_en,
    output logic [WIDTH-1:0] outport
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    logic [31:0] mem  [0:MEM_WORDS-1];
    logic [31:0] regs [0:31];

    logic [31:0] pc_q, pc_d;
    logic [31:0] out_q, out_d;
    logic [31:0] instr, rs1_v, rs2_v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] mem_addr, ld_val, rd_val;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        is_store, is_out, rd_we, st_en, take;
    logic        unused_bits;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    assign instr  = mem[pc_q[AW+1:2]];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    // x0 is cleared by reset and never written, so a plain array read returns 0 for it.
    assign rs1_v  = regs[instr[19:15]];
    assign rs2_v  = regs[instr[24:20]];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign is_store = (instr[6:0] == OP_STORE);
    assign mem_addr = rs1_v + (is_store ? imm_s : imm_i);
    assign is_out   = (mem_addr[31:2] == OUT_ADDR[31:2]);
    assign ld_val   = is_out ? out_q : mem[mem_addr[AW+1:2]];

    assign unused_bits = ^{flash_addr[WIDTH-1:AW+2], flash_addr[1:0], mem_addr[1:0]};

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = (rs1_v == rs2_v);
            3'b001:  take = (rs1_v != rs2_v);
            3'b100:  take = ($signed(rs1_v) <  $signed(rs2_v));
            3'b101:  take = ($signed(rs1_v) >= $signed(rs2_v));
            3'b110:  take = (rs1_v <  rs2_v);
            3'b111:  take = (rs1_v >= rs2_v);
            default: take = 1'b0;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d   = pc_q + 32'd4;
        out_d  = out_q;
        rd_we  = 1'b0;
        rd_val = '0;
        st_en  = 1'b0;
        case (opcode_e'(instr[6:0]))
            OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
            OP_JAL:    begin rd_we = 1'b1; rd_val = pc_q + 32'd4; pc_d = pc_q + imm_j; end
            OP_JALR: begin
                rd_we  = 1'b1;
                rd_val = pc_q + 32'd4;
                pc_d   = (rs1_v + imm_i) & ~32'd1;
            end
            OP_BRANCH: if (take) pc_d = pc_q + imm_b;
            OP_LOAD:   begin rd_we = 1'b1; rd_val = ld_val; end
            OP_STORE: begin
                // The core is halted in reset, but memory has no reset, so gate stores explicitly.
                if (is_out) out_d = rs2_v;
                else        st_en = rst;
            end
            OP_IMM:    begin rd_we = 1'b1; rd_val = alu(funct3, funct3 == 3'b101 && instr[30], rs1_v, imm_i); end
            OP_REG:    begin rd_we = 1'b1; rd_val = alu(funct3, instr[30], rs1_v, rs2_v); end
            default:   ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            out_q <= '0;
        end else begin
            pc_q  <= pc_d;
            out_q <= out_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rd_we && rd != 5'd0) begin
            regs[rd] <= rd_val;
        end
    end

    // NOTE: memory is deliberately not reset, so a program flashed during reset survives it.
    always_ff @(posedge clk) begin
        if (flash_en)   mem[flash_addr[AW+1:2]] <= flash_data;
        else if (st_en) mem[mem_addr[AW+1:2]]   <= rs2_v;
    end

    assign outport = out_q;
endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: directed programs plus random programs checked against an
// instruction-level reference model of the RV32I subset.
module tb_riscv_top;
    localparam int MW = 512;
    localparam logic [31:0] OUT_A = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] flash_addr = '0;
    logic [31:0] flash_data = '0;
    logic        flash_en = 1'b0;
    logic [31:0] outport;

    int total = 0;
    int bad = 0;

    logic [31:0] m_mem [MW];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_out;

    riscv_top dut (
        .clk        (clk),
        .rst        (rst),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .outport    (outport)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
        logic [31:0] a, b, c, d, e, o;
        a = f7; b = rs2; c = rs1; d = f3; e = rd; o = op;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] v, c, d, e, o;
        v = imm; c = rs1; d = f3; e = rd; o = op;
        return {v[11:0], c[4:0], d[2:0], e[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] v, b, c, d;
        v = imm; b = rs2; c = rs1; d = f3;
        return {v[11:5], b[4:0], c[4:0], d[2:0], v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int off, int rs2, int rs1, int f3);
        logic [31:0] v, b, c, d;
        v = off; b = rs2; c = rs1; d = f3;
        return {v[12], v[10:5], b[4:0], c[4:0], d[2:0], v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(int off, int rd);
        logic [31:0] v, e;
        v = off; e = rd;
        return {v[20], v[10:1], v[11], v[19:12], e[4:0], 7'h6F};
    endfunction

    task automatic flash(input logic [31:0] a, input logic [31:0] d);
        flash_addr = a;
        flash_data = d;
        flash_en   = 1'b1;
        @(posedge clk);
        #1;
        flash_en = 1'b0;
        m_mem[(a >> 2) % MW] = d;
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic m_reset();
        m_pc  = '0;
        m_out = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // One architectural step of the reference ISA model.
    task automatic m_step();
        logic [31:0] ins, a, b, ii, si, res, addr, nxt;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          bi, ji;
        bit          wr;
        ins = m_mem[(m_pc >> 2) % MW];
        f3  = ins[14:12];
        rd  = ins[11:7];
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        ii  = $signed(ins) >>> 20;
        si  = {ii[31:5], ins[11:7]};
        bi  = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        ji  = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
        nxt = m_pc + 4;
        wr  = 1'b1;
        res = '0;
        case (ins[6:0])
            7'h37: res = {ins[31:12], 12'h000};
            7'h17: res = m_pc + {ins[31:12], 12'h000};
            7'h6F: begin res = m_pc + 4; nxt = m_pc + ji; end
            7'h67: begin res = m_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                wr = 1'b0;
                case (f3)
                    3'd0: if (a == b) nxt = m_pc + bi;
                    3'd1: if (a != b) nxt = m_pc + bi;
                    3'd4: if ($signed(a) < $signed(b)) nxt = m_pc + bi;
                    3'd5: if ($signed(a) >= $signed(b)) nxt = m_pc + bi;
                    3'd6: if (a < b) nxt = m_pc + bi;
                    3'd7: if (a >= b) nxt = m_pc + bi;
                    default: ;
                endcase
            end
            7'h03: begin
                addr = a + ii;
                res  = (addr >= OUT_A) ? m_out : m_mem[(addr >> 2) % MW];
            end
            7'h23: begin
                wr   = 1'b0;
                addr = a + si;
                if (addr >= OUT_A) m_out = b;
                else               m_mem[(addr >> 2) % MW] = b;
            end
            7'h13: begin
                case (f3)
                    3'd0: res = a + ii;
                    3'd1: res = a << ii[4:0];
                    3'd2: res = ($signed(a) < $signed(ii)) ? 1 : 0;
                    3'd3: res = (a < ii) ? 1 : 0;
                    3'd4: res = a ^ ii;
                    3'd5: res = ins[30] ? $signed(a) >>> ii[4:0] : a >> ii[4:0];
                    3'd6: res = a | ii;
                    default: res = a & ii;
                endcase
            end
            7'h33: begin
                case (f3)
                    3'd0: res = ins[30] ? a - b : a + b;
                    3'd1: res = a << b[4:0];
                    3'd2: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    3'd3: res = (a < b) ? 1 : 0;
                    3'd4: res = a ^ b;
                    3'd5: res = ins[30] ? $signed(a) >>> b[4:0] : a >> b[4:0];
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end
            default: wr = 1'b0;
        endcase
        if (wr && rd != 0) m_regs[rd] = res;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rand_instr();
        int r, rd, rs1, rs2, f3, imm;
        logic [31:0] w;
        r   = $urandom_range(0, 99);
        rd  = $urandom_range(0, 15);
        rs1 = $urandom_range(0, 15);
        rs2 = $urandom_range(0, 15);
        f3  = $urandom_range(0, 7);
        imm = int'($urandom_range(0, 4095)) - 2048;
        if (r < 10) begin
            w = $urandom;
            return {w[31:12], 5'(rd), (r < 5) ? 7'h37 : 7'h17};
        end else if (r < 40) begin
            if (f3 == 1) imm = $urandom_range(0, 31);
            if (f3 == 5) imm = $urandom_range(0, 31) + ($urandom_range(0, 1) * 1024);
            return enc_i(imm, rs1, f3, rd, 7'h13);
        end else if (r < 65) begin
            return enc_r((f3 == 0 || f3 == 5) ? $urandom_range(0, 1) * 32 : 0, rs2, rs1, f3, rd, 7'h33);
        end else if (r < 75) begin
            if (f3 == 2 || f3 == 3) f3 = 0;
            return enc_b((int'($urandom_range(0, 31)) - 16) * 4, rs2, rs1, f3);
        end else if (r < 80) begin
            return enc_j((int'($urandom_range(0, 31)) - 16) * 4, rd);
        end else if (r < 83) begin
            return enc_i(imm, rs1, 0, rd, 7'h67);
        end else if (r < 91) begin
            if (f3 == 3 || f3 > 5) f3 = 2;
            if ($urandom_range(0, 3) == 0) begin rs1 = 0; imm = -4; end
            return enc_i(imm, rs1, f3, rd, 7'h03);
        end else if (r < 99) begin
            if (f3 > 2) f3 = 2;
            if ($urandom_range(0, 3) == 0) begin rs1 = 0; imm = -4; end
            return enc_s(imm, rs2, rs1, f3);
        end
        w = $urandom;
        w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h0F : 7'h73;
        return w;
    endfunction

    task automatic test_reset_and_load();
        #2 rst = 1'b0;
        flash(32'd16, 32'hbeef0016);
        flash(32'd20, 32'hbeef0020);
        flash(32'd24, 32'hbeef0024);
        flash(32'd28, 32'hbeef0028);
        flash(32'd0,  32'h01002083);
        flash(32'd4,  32'h01402103);
        flash(32'd8,  32'h01802183);
        flash(32'd12, 32'h01c02203);
        flash(32'd32, 32'hdeaddead);
        flash(32'd36, enc_j(0, 0));
        total++;
        if (dut.pc_q !== 32'd0 || outport !== 32'd0 || dut.regs[1] !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: pc=%h out=%h x1=%h, required all 0", dut.pc_q, outport, dut.regs[1]);
        end
        rst = 1'b1;
        clk_n(4);
        total++;
        if (dut.regs[1] !== 32'hbeef0016 || dut.regs[2] !== 32'hbeef0020 ||
            dut.regs[3] !== 32'hbeef0024 || dut.regs[4] !== 32'hbeef0028) begin
            bad++;
            $display("FAIL load_words: x1..x4=%h %h %h %h, required beef0016/20/24/28",
                     dut.regs[1], dut.regs[2], dut.regs[3], dut.regs[4]);
        end
        total++;
        if (dut.pc_q !== 32'd16) begin
            bad++;
            $display("FAIL load_pc: pc=%h, required 00000010", dut.pc_q);
        end
        clk_n(7);
        total++;
        if (dut.pc_q !== 32'd36 || dut.regs[1] !== 32'hbeef0016 || dut.regs[5] !== 32'd0) begin
            bad++;
            $display("FAIL nop_words: pc=%h x1=%h x5=%h, required 00000024 beef0016 0",
                     dut.pc_q, dut.regs[1], dut.regs[5]);
        end
    endtask

    task automatic test_outport();
        rst = 1'b0;
        flash(32'h7FC, 32'h5A5A5A5A);
        flash(32'd0,  enc_i(-1, 0, 0, 5, 7'h13));
        flash(32'd4,  enc_s(-4, 5, 0, 2));
        flash(32'd8,  enc_i(-4, 0, 2, 8, 7'h03));
        flash(32'd12, enc_j(0, 0));
        total++;
        if (outport !== 32'd0) begin
            bad++;
            $display("FAIL out_in_reset: outport=%h, required 0", outport);
        end
        rst = 1'b1;
        clk_n(1);
        total++;
        if (outport !== 32'd0 || dut.regs[5] !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL out_clk1: outport=%h x5=%h, required 0 ffffffff", outport, dut.regs[5]);
        end
        clk_n(1);
        total++;
        if (outport !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL out_clk2: outport=%h, required ffffffff", outport);
        end
        clk_n(1);
        total++;
        if (dut.regs[8] !== 32'hFFFFFFFF || dut.mem[511] !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL out_readback: x8=%h mem511=%h, required ffffffff 5a5a5a5a", dut.regs[8], dut.mem[511]);
        end
    endtask

    task automatic test_midrun_reset();
        logic regs_zero;
        rst = 1'b0;
        #1;
        regs_zero = 1'b1;
        for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'd0) regs_zero = 1'b0;
        total++;
        if (dut.pc_q !== 32'd0 || outport !== 32'd0 || !regs_zero) begin
            bad++;
            $display("FAIL async_reset: pc=%h out=%h regs_zero=%0b, required 0 0 1", dut.pc_q, outport, regs_zero);
        end
        total++;
        if (dut.mem[0] !== m_mem[0] || dut.mem[1] !== m_mem[1] || dut.mem[2] !== m_mem[2] ||
            dut.mem[3] !== m_mem[3] || dut.mem[511] !== m_mem[511]) begin
            bad++;
            $display("FAIL reset_keeps_mem: mem0=%h mem1=%h, required %h %h", dut.mem[0], dut.mem[1], m_mem[0], m_mem[1]);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clk_n(3);
        total++;
        if (outport !== 32'hFFFFFFFF || dut.regs[5] !== 32'hFFFFFFFF ||
            dut.regs[8] !== 32'hFFFFFFFF || dut.pc_q !== 32'd12) begin
            bad++;
            $display("FAIL rerun: out=%h x5=%h x8=%h pc=%h, required ffffffff ffffffff ffffffff 0000000c",
                     outport, dut.regs[5], dut.regs[8], dut.pc_q);
        end
    endtask

    task automatic test_x0();
        rst = 1'b0;
        flash(32'd0,  enc_i(5, 0, 0, 0, 7'h13));
        flash(32'd4,  enc_i(9, 0, 0, 6, 7'h13));
        flash(32'd8,  enc_r(0, 0, 0, 0, 6, 7'h33));
        flash(32'd12, enc_j(0, 0));
        rst = 1'b1;
        clk_n(1);
        total++;
        if (dut.regs[0] !== 32'd0) begin
            bad++;
            $display("FAIL x0_write: x0=%h, required 0", dut.regs[0]);
        end
        clk_n(1);
        total++;
        if (dut.regs[6] !== 32'd9) begin
            bad++;
            $display("FAIL x6_addi: x6=%h, required 9", dut.regs[6]);
        end
        clk_n(1);
        total++;
        if (dut.regs[6] !== 32'd0 || dut.regs[0] !== 32'd0) begin
            bad++;
            $display("FAIL x0_read: x6=%h x0=%h, required 0 0", dut.regs[6], dut.regs[0]);
        end
    endtask

    task automatic test_branch_jal();
        rst = 1'b0;
        flash(32'd0,  enc_b(8, 0, 0, 0));
        flash(32'd4,  enc_i(1, 0, 0, 7, 7'h13));
        flash(32'd8,  enc_j(8, 1));
        flash(32'd12, enc_i(2, 0, 0, 7, 7'h13));
        flash(32'd16, enc_b(8, 0, 0, 1));
        flash(32'd20, enc_j(0, 0));
        rst = 1'b1;
        clk_n(1);
        total++;
        if (dut.pc_q !== 32'd8) begin
            bad++;
            $display("FAIL beq_taken: pc=%h, required 00000008", dut.pc_q);
        end
        clk_n(1);
        total++;
        if (dut.pc_q !== 32'd16 || dut.regs[1] !== 32'd12) begin
            bad++;
            $display("FAIL jal: pc=%h x1=%h, required 00000010 0000000c", dut.pc_q, dut.regs[1]);
        end
        clk_n(1);
        total++;
        if (dut.pc_q !== 32'd20) begin
            bad++;
            $display("FAIL bne_not_taken: pc=%h, required 00000014", dut.pc_q);
        end
        clk_n(1);
        total++;
        if (dut.pc_q !== 32'd20 || dut.regs[7] !== 32'd0) begin
            bad++;
            $display("FAIL skip: pc=%h x7=%h, required 00000014 0", dut.pc_q, dut.regs[7]);
        end
    endtask

    task automatic test_flash_priority();
        rst = 1'b0;
        flash(32'd0,  enc_i(32'h55, 0, 0, 5, 7'h13));
        flash(32'd4,  enc_s(64, 5, 0, 2));
        flash(32'd8,  enc_s(68, 5, 0, 2));
        flash(32'd12, enc_j(0, 0));
        flash(32'd64, 32'd0);
        flash(32'd68, 32'd0);
        rst = 1'b1;
        clk_n(1);
        flash(32'h840, 32'h12345678);
        clk_n(1);
        total++;
        if (dut.mem[16] !== 32'h12345678) begin
            bad++;
            $display("FAIL flash_priority: mem16=%h, required 12345678", dut.mem[16]);
        end
        total++;
        if (dut.mem[17] !== 32'h55 || dut.pc_q !== 32'd12) begin
            bad++;
            $display("FAIL plain_store: mem17=%h pc=%h, required 00000055 0000000c", dut.mem[17], dut.pc_q);
        end
    endtask

    task automatic test_random(input int prog);
        logic ok, mem_ok;
        int bad_reg;
        rst = 1'b0;
        for (int i = 0; i < MW; i++) flash(32'(i * 4), rand_instr());
        m_reset();
        rst = 1'b1;
        for (int step = 0; step < 300; step++) begin
            if (step == 150) begin
                rst = 1'b0;
                #1;
                m_reset();
                ok = 1'b1;
                for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'd0) ok = 1'b0;
                total++;
                if (!ok || dut.pc_q !== 32'd0 || outport !== 32'd0) begin
                    bad++;
                    $display("FAIL rand_reset p%0d: pc=%h out=%h regs_zero=%0b, required 0 0 1",
                             prog, dut.pc_q, outport, ok);
                end
                mem_ok = 1'b1;
                for (int i = 0; i < MW; i++) if (dut.mem[i] !== m_mem[i]) mem_ok = 1'b0;
                total++;
                if (!mem_ok) begin
                    bad++;
                    $display("FAIL rand_mem p%0d: memory differs from model after %0d steps", prog, step);
                end
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
            m_step();
            @(posedge clk);
            #1;
            bad_reg = -1;
            for (int i = 31; i >= 0; i--) if (dut.regs[i] !== m_regs[i]) bad_reg = i;
            total++;
            if (dut.pc_q !== m_pc || outport !== m_out || bad_reg >= 0) begin
                bad++;
                if (bad_reg < 0) bad_reg = 0;
                $display("FAIL rand_step p%0d s%0d: pc=%h want %h out=%h want %h x%0d=%h want %h",
                         prog, step, dut.pc_q, m_pc, outport, m_out, bad_reg, dut.regs[bad_reg], m_regs[bad_reg]);
                break;
            end
        end
    endtask

    initial begin
        test_reset_and_load();
        test_outport();
        test_midrun_reset();
        test_x0();
        test_branch_jal();
        test_flash_priority();
        test_random(0);
        test_random(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
